axi4_stream_target_type_2: RTL and testbench

AXI4_STREAM_TARGET_TYPE_2 -- requirements
Module: axi4_stream_target_type_2

---
 rtl/axi4_stream_type_2_pkg.sv | 33 +++
 rtl/axi4_stream_tready_shaper.sv | 47 ++++
 rtl/axi4_stream_target_type_2.sv | 169 ++++++++++++++++
 tb/tb_axi4_stream_target_type_2.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_stream_type_2_pkg.sv
// axi4_stream_type_2_pkg: shared constants, FSM state type and expected-tdata helper for the type-2 stream pair
package axi4_stream_type_2_pkg;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_TDEST    = 3'd1;
    localparam logic [2:0] ERR_TID      = 3'd2;
    localparam logic [2:0] ERR_TDATA    = 3'd3;
    localparam logic [2:0] ERR_TLAST    = 3'd4;
    localparam logic [2:0] ERR_OVERFLOW = 3'd5;

    localparam string MODE_ALWAYS   = "ALWAYS";
    localparam string MODE_PERIODIC = "PERIODIC";
    localparam string MODE_LFSR     = "LFSR";

    localparam string TRIG_NONE   = "NONE";
    localparam string TRIG_PACKET = "PACKET";
    localparam string TRIG_FRAME  = "FRAME";
    localparam string TRIG_STREAM = "STREAM";

    typedef logic [1:0] state_t;
    localparam state_t ST_RUN   = 2'd0;
    localparam state_t ST_DONE  = 2'd1;
    localparam state_t ST_ERROR = 2'd2;

    // Payload layout: tid in the top id_w bits, sequence number zero-extended below it.
    function automatic logic [63:0] exp_tdata(input logic [31:0] tid, input logic [31:0] seq,
                                              input int unsigned data_w, input int unsigned id_w);
        logic [63:0] mask;
        mask = (64'd1 << (data_w - id_w)) - 64'd1;
        return (64'(tid) << (data_w - id_w)) | (64'(seq) & mask);
    endfunction

endpackage

// File: rtl/axi4_stream_tready_shaper.sv
// axi4_stream_tready_shaper: generates the tready pattern (always, periodic or LFSR driven)
module axi4_stream_tready_shaper
    import axi4_stream_type_2_pkg::*;
#(
    parameter string       Mode         = "PERIODIC",
    parameter int unsigned CyclesActive = 3,
    parameter int unsigned CyclesPause  = 8,
    parameter logic [15:0] LfsrSeed     = 16'hACE1
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tready_o
);

    localparam int unsigned Period = (CyclesActive + CyclesPause > 0) ? CyclesActive + CyclesPause : 1;
    localparam int unsigned CntW   = (Period > 1) ? $clog2(Period) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic            ready_q, ready_d;
    logic            run_q;

    // Free-running period counter, LFSR step and next periodic/always ready level
    always_comb begin
        cnt_d   = (32'(cnt_q) == Period - 1) ? '0 : cnt_q + 1'b1;
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        ready_d = (Mode == MODE_ALWAYS) || (CyclesPause == 0) || (32'(cnt_q) < CyclesActive);
    end

    // Pattern state; run_q keeps the LFSR-driven tready low until the first edge after reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            lfsr_q  <= LfsrSeed;
            ready_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            ready_q <= ready_d;
            run_q   <= 1'b1;
        end
    end

    assign tready_o = (Mode == MODE_LFSR) ? (run_q & lfsr_q[0]) : ready_q;

endmodule

// File: rtl/axi4_stream_target_type_2.sv
// axi4_stream_target_type_2: AXI4-Stream sink checking interleaved type-2 streams for content and framing
module axi4_stream_target_type_2
    import axi4_stream_type_2_pkg::*;
#(
    parameter int unsigned AxiStreamTargetIfTDataWidth         = 32,
    parameter int unsigned AxiStreamTargetIfTIdWidth           = 8,
    parameter int unsigned AxiStreamTargetIfTDestWidth         = 8,
    parameter int unsigned AxiStreamTargetIfNumStreams         = 4,
    parameter int unsigned AxiStreamTargetIfTId                = 'h11,
    parameter int unsigned AxiStreamTargetIfTDest              = 'hDE,
    parameter string       AxiStreamTargetIfTargetMode         = "PERIODIC",
    parameter int unsigned AxiStreamTargetIfCyclesActive       = 3,
    parameter int unsigned AxiStreamTargetIfCyclesPause        = 8,
    parameter int unsigned AxiStreamTargetIfTransfersPerPacket = 2,
    parameter int unsigned AxiStreamTargetIfPacketsPerFrame    = 2,
    parameter int unsigned AxiStreamTargetIfFramesPerStream    = 2,
    parameter string       AxiStreamTargetIfTlastFlagTrigger   = "STREAM",
    parameter logic [15:0] AxiStreamTargetIfLfsrSeed           = 16'hACE1
) (
    input  logic                                   clk_s_axis_i,
    input  logic                                   rst_s_axis_ni,
    input  logic                                   s_axis_tvalid_i,
    output logic                                   s_axis_tready_o,
    input  logic [AxiStreamTargetIfTDataWidth-1:0] s_axis_tdata_i,
    input  logic                                   s_axis_tlast_i,
    input  logic [AxiStreamTargetIfTIdWidth-1:0]   s_axis_tid_i,
    input  logic [AxiStreamTargetIfTDestWidth-1:0] s_axis_tdest_i,
    output logic                                   s_axis_terror_o,
    output logic [2:0]                             error_code_o,
    output logic [AxiStreamTargetIfNumStreams-1:0] stream_done_o,
    output logic                                   done_o,
    output logic [31:0]                            transfers_o
);

    localparam int unsigned DW    = AxiStreamTargetIfTDataWidth;
    localparam int unsigned IW    = AxiStreamTargetIfTIdWidth;
    localparam int unsigned NS    = AxiStreamTargetIfNumStreams;
    localparam int unsigned TId   = AxiStreamTargetIfTId;
    localparam int unsigned TPP   = AxiStreamTargetIfTransfersPerPacket;
    localparam int unsigned PPF   = AxiStreamTargetIfPacketsPerFrame;
    localparam int unsigned FPS   = AxiStreamTargetIfFramesPerStream;
    localparam int unsigned Total = TPP * PPF * FPS;
    localparam int unsigned TPW   = $clog2(TPP + 1);
    localparam int unsigned PFW   = $clog2(PPF + 1);
    localparam int unsigned FSW   = $clog2(FPS + 1);
    localparam int unsigned SQW   = $clog2(Total + 1);
    localparam int unsigned SelW  = (NS > 1) ? $clog2(NS) : 1;
    localparam string       Trig  = AxiStreamTargetIfTlastFlagTrigger;

    logic [TPW-1:0] tcnt_q [NS];
    logic [TPW-1:0] tcnt_d [NS];
    logic [PFW-1:0] pcnt_q [NS];
    logic [PFW-1:0] pcnt_d [NS];
    logic [FSW-1:0] fcnt_q [NS];
    logic [FSW-1:0] fcnt_d [NS];
    logic [SQW-1:0] seq_q  [NS];
    logic [SQW-1:0] seq_d  [NS];
    logic [NS-1:0]  sdone_q, sdone_d;
    state_t         state_q, state_d;
    logic           terror_q, terror_d;
    logic [2:0]     code_q, code_d;
    logic [31:0]    xfer_q, xfer_d;

    logic           hs, tid_ok, dest_ok, upd;
    logic           last_t, last_p, last_f, exp_last;
    logic [31:0]    tid_ext;
    logic [SelW-1:0] sel;
    logic [DW-1:0]  exp_data;
    logic [2:0]     chk_code, fail_code;

    axi4_stream_tready_shaper #(
        .Mode         (AxiStreamTargetIfTargetMode),
        .CyclesActive (AxiStreamTargetIfCyclesActive),
        .CyclesPause  (AxiStreamTargetIfCyclesPause),
        .LfsrSeed     (AxiStreamTargetIfLfsrSeed)
    ) u_shaper (
        .clk_i    (clk_s_axis_i),
        .rst_ni   (rst_s_axis_ni),
        .tready_o (s_axis_tready_o)
    );

    // Decode the beat: stream select, expected payload/tlast and lowest failing check code
    always_comb begin
        hs       = s_axis_tvalid_i & s_axis_tready_o;
        tid_ext  = 32'(s_axis_tid_i);
        tid_ok   = (tid_ext >= TId) && (tid_ext < TId + NS);
        dest_ok  = 32'(s_axis_tdest_i) == AxiStreamTargetIfTDest;
        sel      = tid_ok ? SelW'(tid_ext - TId) : '0;
        last_t   = 32'(tcnt_q[sel]) == TPP - 1;
        last_p   = last_t && (32'(pcnt_q[sel]) == PPF - 1);
        last_f   = last_p && (32'(fcnt_q[sel]) == FPS - 1);
        exp_last = (Trig == TRIG_PACKET) ? last_t :
                   (Trig == TRIG_FRAME)  ? last_p :
                   (Trig == TRIG_STREAM) ? last_f : 1'b0;
        exp_data = DW'(exp_tdata(TId + 32'(sel), 32'(seq_q[sel]), DW, IW));
        chk_code = !dest_ok                         ? ERR_TDEST    :
                   !tid_ok                          ? ERR_TID      :
                   (s_axis_tdata_i != exp_data)     ? ERR_TDATA    :
                   (s_axis_tlast_i != exp_last)     ? ERR_TLAST    :
                   sdone_q[sel]                     ? ERR_OVERFLOW : ERR_NONE;
        fail_code = (state_q == ST_DONE) ? ERR_OVERFLOW : chk_code;
    end

    // Per-stream counters advance on every addressable beat of an unfinished stream, wrapping in the same cycle
    always_comb begin
        tcnt_d  = tcnt_q;
        pcnt_d  = pcnt_q;
        fcnt_d  = fcnt_q;
        seq_d   = seq_q;
        sdone_d = sdone_q;
        upd     = hs && dest_ok && tid_ok && !sdone_q[sel];
        if (upd) begin
            seq_d[sel]  = seq_q[sel] + 1'b1;
            tcnt_d[sel] = last_t ? '0 : tcnt_q[sel] + 1'b1;
            if (last_t) pcnt_d[sel] = last_p ? '0 : pcnt_q[sel] + 1'b1;
            if (last_p) fcnt_d[sel] = last_f ? '0 : fcnt_q[sel] + 1'b1;
            if (last_f) sdone_d[sel] = 1'b1;
        end
    end

    // Global FSM and first-error capture; ERROR is terminal so the first code is held
    always_comb begin
        state_d  = state_q;
        terror_d = terror_q;
        code_d   = code_q;
        if (hs && (state_q != ST_ERROR) && (fail_code != ERR_NONE)) begin
            state_d  = ST_ERROR;
            terror_d = 1'b1;
            code_d   = fail_code;
        end else if ((state_q == ST_RUN) && (&sdone_q)) begin
            state_d  = ST_DONE;
        end
        xfer_d = (hs && (xfer_q != '1)) ? xfer_q + 32'd1 : xfer_q;
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge clk_s_axis_i or negedge rst_s_axis_ni) begin
        if (!rst_s_axis_ni) begin
            for (int i = 0; i < NS; i++) begin
                tcnt_q[i] <= '0;
                pcnt_q[i] <= '0;
                fcnt_q[i] <= '0;
                seq_q[i]  <= '0;
            end
            sdone_q  <= '0;
            state_q  <= ST_RUN;
            terror_q <= 1'b0;
            code_q   <= ERR_NONE;
            xfer_q   <= '0;
        end else begin
            tcnt_q   <= tcnt_d;
            pcnt_q   <= pcnt_d;
            fcnt_q   <= fcnt_d;
            seq_q    <= seq_d;
            sdone_q  <= sdone_d;
            state_q  <= state_d;
            terror_q <= terror_d;
            code_q   <= code_d;
            xfer_q   <= xfer_d;
        end
    end

    assign s_axis_terror_o = terror_q;
    assign error_code_o    = code_q;
    assign stream_done_o   = sdone_q;
    assign done_o          = state_q == ST_DONE;
    assign transfers_o     = xfer_q;

endmodule

// File: tb/tb_axi4_stream_target_type_2.sv
// tb_axi4_stream_target_type_2: directed scenarios for the type-2 stream target
module tb_axi4_stream_target_type_2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tvalid = 1'b0, tlast = 1'b0;
    logic [31:0] tdata = '0;
    logic [7:0]  tid = '0, tdest = '0;
    logic        tready, terror, done;
    logic [2:0]  code;
    logic [3:0]  sdone;
    logic [31:0] xfer;

    logic        p_tvalid = 1'b0, p_tlast = 1'b0;
    logic [31:0] p_tdata = '0;
    logic [7:0]  p_tid = '0, p_tdest = '0;
    logic        p_tready, p_terror, p_done;
    logic [2:0]  p_code;
    logic [3:0]  p_sdone;
    logic [31:0] p_xfer;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    axi4_stream_target_type_2 dut (
        .clk_s_axis_i    (clk),
        .rst_s_axis_ni   (rst_n),
        .s_axis_tvalid_i (tvalid),
        .s_axis_tready_o (tready),
        .s_axis_tdata_i  (tdata),
        .s_axis_tlast_i  (tlast),
        .s_axis_tid_i    (tid),
        .s_axis_tdest_i  (tdest),
        .s_axis_terror_o (terror),
        .error_code_o    (code),
        .stream_done_o   (sdone),
        .done_o          (done),
        .transfers_o     (xfer)
    );

    axi4_stream_target_type_2 #(
        .AxiStreamTargetIfTargetMode       ("ALWAYS"),
        .AxiStreamTargetIfTlastFlagTrigger ("PACKET")
    ) dut_p (
        .clk_s_axis_i    (clk),
        .rst_s_axis_ni   (rst_n),
        .s_axis_tvalid_i (p_tvalid),
        .s_axis_tready_o (p_tready),
        .s_axis_tdata_i  (p_tdata),
        .s_axis_tlast_i  (p_tlast),
        .s_axis_tid_i    (p_tid),
        .s_axis_tdest_i  (p_tdest),
        .s_axis_terror_o (p_terror),
        .error_code_o    (p_code),
        .stream_done_o   (p_sdone),
        .done_o          (p_done),
        .transfers_o     (p_xfer)
    );

    function automatic logic [31:0] beat(input int k, input int s);
        logic [7:0] id;
        id = 8'(8'h11 + k);
        return {id, 24'(s)};
    endfunction

    task automatic apply_reset;
        tvalid = 1'b0;
        p_tvalid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] id, input logic [31:0] d, input logic l, input logic [7:0] dst);
        int n;
        tid = id; tdata = d; tlast = l; tdest = dst; tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!tready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!tready) begin
            total++;
            $display("FAIL send_timeout: tready=%0b after %0d cycles, required 1", tready, n);
        end
        @(posedge clk);
        #1 tvalid = 1'b0;
    endtask

    task automatic psend(input logic [7:0] id, input logic [31:0] d, input logic l);
        p_tid = id; p_tdata = d; p_tlast = l; p_tdest = 8'hDE; p_tvalid = 1'b1;
        @(posedge clk);
        #1 p_tvalid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({tready, terror, code, sdone, done} !== 10'b0) $display("FAIL reset_flags: got %b required 0", {tready, terror, code, sdone, done}); else passed++;
        total++; if (xfer !== 32'd0) $display("FAIL reset_xfer: got %0d required 0", xfer); else passed++;
        total++; if (p_tready !== 1'b0) $display("FAIL reset_p_tready: got %0b required 0", p_tready); else passed++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (p_tready !== 1'b1) $display("FAIL always_first_edge: got %0b required 1", p_tready); else passed++;
        total++; if (tready !== 1'b1) $display("FAIL periodic_first_edge: got %0b required 1", tready); else passed++;
    endtask

    task automatic test_all_streams;
        apply_reset();
        for (int s = 0; s < 8; s++)
            for (int k = 0; k < 4; k++)
                send(8'(8'h11 + k), beat(k, s), s == 7, 8'hDE);
        repeat (2) @(posedge clk);
        #1;
        total++; if (done !== 1'b1) $display("FAIL all_done: got %0b required 1", done); else passed++;
        total++; if (xfer !== 32'd32) $display("FAIL all_xfer: got %0d required 32", xfer); else passed++;
        total++; if (terror !== 1'b0) $display("FAIL all_terror: got %0b required 0", terror); else passed++;
        total++; if (sdone !== 4'hF) $display("FAIL all_sdone: got %h required F", sdone); else passed++;
        total++; if (code !== 3'd0) $display("FAIL all_code: got %0d required 0", code); else passed++;
        send(8'h11, beat(0, 8), 1'b0, 8'hDE);
        total++; if (code !== 3'd5) $display("FAIL done_extra_code: got %0d required 5", code); else passed++;
        total++; if ({terror, done} !== 2'b10) $display("FAIL done_extra_state: terror,done=%b required 10", {terror, done}); else passed++;
        total++; if (xfer !== 32'd33) $display("FAIL done_extra_xfer: got %0d required 33", xfer); else passed++;
    endtask

    task automatic test_tdest;
        apply_reset();
        send(8'h11, beat(0, 0), 1'b0, 8'hDE);
        total++; if (terror !== 1'b0) $display("FAIL tdest_pre: got %0b required 0", terror); else passed++;
        send(8'h12, beat(1, 0), 1'b0, 8'hDF);
        total++; if (terror !== 1'b1) $display("FAIL tdest_terror: got %0b required 1", terror); else passed++;
        total++; if (code !== 3'd1) $display("FAIL tdest_code: got %0d required 1", code); else passed++;
        total++; if (xfer !== 32'd2) $display("FAIL tdest_xfer: got %0d required 2", xfer); else passed++;
        for (int s = 0; s < 7; s++) send(8'h12, beat(1, s), 1'b0, 8'hDE);
        total++; if (sdone !== 4'b0000) $display("FAIL tdest_no_advance: got %b required 0000", sdone); else passed++;
        send(8'h12, beat(1, 7), 1'b1, 8'hDE);
        total++; if (sdone !== 4'b0010) $display("FAIL tdest_stream1_done: got %b required 0010", sdone); else passed++;
        total++; if (code !== 3'd1) $display("FAIL tdest_code_held: got %0d required 1", code); else passed++;
    endtask

    task automatic test_tdata;
        logic [31:0] d;
        apply_reset();
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 4; k++) begin
                d = beat(k, s);
                if (s == 3 && k == 2) d[0] = ~d[0];
                send(8'(8'h11 + k), d, s == 3 && k == 3, 8'hDE);
                if (s == 2 && k == 3) begin
                    total++; if (terror !== 1'b0) $display("FAIL tdata_pre: got %0b required 0", terror); else passed++;
                end
                if (s == 3 && k == 2) begin
                    total++; if ({terror, code} !== 4'b1011) $display("FAIL tdata_code: terror,code=%b required 1011", {terror, code}); else passed++;
                end
            end
        total++; if (code !== 3'd3) $display("FAIL tdata_code_held: got %0d required 3", code); else passed++;
    endtask

    task automatic test_packet;
        apply_reset();
        @(posedge clk);
        #1;
        total++; if (p_tready !== 1'b1) $display("FAIL packet_tready: got %0b required 1", p_tready); else passed++;
        psend(8'h11, beat(0, 0), 1'b0);
        psend(8'h11, beat(0, 1), 1'b1);
        total++; if ({p_terror, p_xfer} !== {1'b0, 32'd2}) $display("FAIL packet_good: terror=%0b xfer=%0d required 0,2", p_terror, p_xfer); else passed++;
        psend(8'h12, beat(1, 0), 1'b0);
        psend(8'h12, beat(1, 1), 1'b0);
        total++; if ({p_terror, p_code} !== 4'b1100) $display("FAIL packet_tlast: terror,code=%b required 1100", {p_terror, p_code}); else passed++;
    endtask

    task automatic test_overflow;
        apply_reset();
        for (int s = 0; s < 8; s++) send(8'h11, beat(0, s), s == 7, 8'hDE);
        total++; if ({sdone, terror, done} !== 6'b000100) $display("FAIL ovf_pre: sdone,terror,done=%b required 000100", {sdone, terror, done}); else passed++;
        send(8'h11, beat(0, 8), 1'b0, 8'hDE);
        total++; if ({terror, code} !== 4'b1101) $display("FAIL ovf_code: terror,code=%b required 1101", {terror, code}); else passed++;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({done, code} !== 4'b0101) $display("FAIL ovf_error_state: done,code=%b required 0101", {done, code}); else passed++;
    endtask

    task automatic test_periodic;
        logic e;
        tvalid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            e = (i % 11) < 3;
            total++; if (tready !== e) $display("FAIL periodic_cycle%0d: got %0b required %0b", i, tready, e); else passed++;
        end
        for (int s = 0; s < 3; s++) send(8'h11, beat(0, s), 1'b0, 8'hDE);
        total++; if (xfer !== 32'd3) $display("FAIL midreset_pre: got %0d required 3", xfer); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({tready, terror, code, sdone, done} !== 10'b0) $display("FAIL midreset_flags: got %b required 0", {tready, terror, code, sdone, done}); else passed++;
        total++; if (xfer !== 32'd0) $display("FAIL midreset_xfer: got %0d required 0", xfer); else passed++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int s = 0; s < 8; s++) send(8'h11, beat(0, s), s == 7, 8'hDE);
        total++; if ({sdone, terror} !== 5'b00010) $display("FAIL restart_stream: sdone,terror=%b required 00010", {sdone, terror}); else passed++;
        total++; if (xfer !== 32'd8) $display("FAIL restart_xfer: got %0d required 8", xfer); else passed++;
    endtask

    initial begin
        test_reset();
        test_all_streams();
        test_tdest();
        test_tdata();
        test_packet();
        test_overflow();
        test_periodic();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
